sha256_arb: RTL

Shared-resource arbiter for the single SHA-256 compression core in the signing datapath. Accepts hash-block requests from up to NREQ requesters (message-random generator, message hash, FORS sign, WOTS sign), grants one at a time, drives the core's start/operand bus from registered copies of the winner's operands, and routes the core's completion back as a per-requester done pulse. The block replaces the hand-muxed core operand select in the main sequencing FSM.

---
 rtl/sha256_arb_if.sv | 42 ++++
 rtl/sha256_arb.sv | 108 ++++++++++
 2 files changed

// File: rtl/sha256_arb_if.sv
// Bundle between the requesters, the SHA-256 core and the sha256_arb arbiter.
// The arbiter side uses the slave modport; requesters/core models use master.
interface sha256_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     req_1st;
  logic [NREQ-1:0]     req_seed;
  logic [NREQ-1:0]     req_final;
  logic [NREQ*256-1:0] req_state;
  logic [NREQ*512-1:0] req_data;
  logic [NREQ*7-1:0]   req_len;
  logic [NREQ-1:0]     req_done;
  logic [255:0]        dout;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic                sha256_start;
  logic                sha256_1st;
  logic                sha256_seed;
  logic                sha256_final;
  logic [255:0]        sha256_state;
  logic [511:0]        sha256_din;
  logic [6:0]          sha256_len;
  logic                sha256_done;
  logic [255:0]        sha256_dout;

  modport slave (
    input  req, req_1st, req_seed, req_final, req_state, req_data, req_len,
    input  sha256_done, sha256_dout,
    output req_done, dout, grant, busy,
    output sha256_start, sha256_1st, sha256_seed, sha256_final,
    output sha256_state, sha256_din, sha256_len
  );

  modport master (
    output req, req_1st, req_seed, req_final, req_state, req_data, req_len,
    output sha256_done, sha256_dout,
    input  req_done, dout, grant, busy,
    input  sha256_start, sha256_1st, sha256_seed, sha256_final,
    input  sha256_state, sha256_din, sha256_len
  );
endinterface

// File: rtl/sha256_arb.sv
// Arbiter sharing one SHA-256 compression core among NREQ requesters.
// Define SHA256_ARB_RR_EN for round-robin; otherwise lowest index wins.
module sha256_arb #(
  parameter int NREQ = 4
) (
  input logic         clk,
  input logic         rst,
  sha256_arb_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic          win_vld;
  logic [IW-1:0] win_idx;

`ifdef SHA256_ARB_RR_EN
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;

  // First requester at or after the pointer, wrapping past NREQ-1.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!win_vld && bus.req[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        win_vld = 1'b1;
        win_idx = IW'(k);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bus.req_done     <= '0;
      bus.dout         <= '0;
      bus.grant        <= '0;
      bus.busy         <= 1'b0;
      bus.sha256_start <= 1'b0;
      bus.sha256_1st   <= 1'b0;
      bus.sha256_seed  <= 1'b0;
      bus.sha256_final <= 1'b0;
      bus.sha256_state <= '0;
      bus.sha256_din   <= '0;
      bus.sha256_len   <= '0;
`ifdef SHA256_ARB_RR_EN
      ptr              <= '0;
      gnt_idx          <= '0;
`endif
    end else begin
      bus.sha256_start <= 1'b0;
      bus.req_done     <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            bus.grant        <= NREQ'(1) << win_idx;
            bus.sha256_1st   <= bus.req_1st[win_idx];
            bus.sha256_seed  <= bus.req_seed[win_idx];
            bus.sha256_final <= bus.req_final[win_idx];
            bus.sha256_state <= bus.req_state[int'(win_idx)*256 +: 256];
            bus.sha256_din   <= bus.req_data[int'(win_idx)*512 +: 512];
            bus.sha256_len   <= bus.req_len[int'(win_idx)*7 +: 7];
            bus.sha256_start <= 1'b1;
            bus.busy         <= 1'b1;
`ifdef SHA256_ARB_RR_EN
            gnt_idx          <= win_idx;
`endif
            state            <= BUSY;
          end
        end
        BUSY: begin
          // Operands and grant stay frozen until the core reports completion.
          if (bus.sha256_done) begin
            bus.dout     <= bus.sha256_dout;
            bus.req_done <= bus.grant;
            state        <= DONE;
          end
        end
        DONE: begin
`ifdef SHA256_ARB_RR_EN
          ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
          bus.grant <= '0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
